// File: rtl/grf_param_if.sv
// Register file bus: decode-side read ports, writeback (W0) port,
// MDU (W1) valid/ready port and the per-commit trace outputs.
interface grf_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_pending;

    logic                     w0_we;
    logic [ADDR_W-1:0]        w0_addr;
    logic [DATA_W-1:0]        w0_data;
    logic [31:0]              w0_pc;

    logic                     w1_valid;
    logic                     w1_ready;
    logic [ADDR_W-1:0]        w1_addr;
    logic [DATA_W-1:0]        w1_data;
    logic [31:0]              w1_pc;

    logic                     trace_valid;
    logic [ADDR_W-1:0]        trace_addr;
    logic [DATA_W-1:0]        trace_data;
    logic [31:0]              trace_pc;

    // Pipeline / MDU side
    modport master (
        output rd_addr, w0_we, w0_addr, w0_data, w0_pc,
               w1_valid, w1_addr, w1_data, w1_pc,
        input  rd_data, rd_pending, w1_ready,
               trace_valid, trace_addr, trace_data, trace_pc
    );

    // Register file side
    modport slave (
        input  rd_addr, w0_we, w0_addr, w0_data, w0_pc,
               w1_valid, w1_addr, w1_data, w1_pc,
        output rd_data, rd_pending, w1_ready,
               trace_valid, trace_addr, trace_data, trace_pc
    );
endinterface

// File: rtl/grf_param.sv
// Parametrised GPR file: rising-edge commits with same-cycle read bypass,
// a low-priority MDU write port with a one-entry hold buffer, and a commit trace.

// One read port: x0 forcing, commit bypass and hold-hazard flag.
module grf_rd_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] arr_data,
    input  logic              cm_valid,
    input  logic [ADDR_W-1:0] cm_addr,
    input  logic [DATA_W-1:0] cm_data,
    input  logic              hold_open,
    input  logic [ADDR_W-1:0] hold_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_pending
);
    // Bypass priority: x0, then the value committing this cycle, then the array
    always_comb begin
        rd_data = arr_data;
        if (rd_addr == '0)
            rd_data = '0;
        else if (cm_valid && cm_addr == rd_addr)
            rd_data = cm_data;
    end

    assign rd_pending = hold_open && (hold_addr == rd_addr) && (rd_addr != '0);
endmodule

module grf_param #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic         clk,
    input  logic         reset,
    grf_param_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [31:0]       pc;
    } wr_t;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              hold_valid_q, hold_valid_d;
    wr_t               hold_q, hold_d;

    logic w0_eff, w1_fire, w1_live;
    logic cm_valid, hold_cm;
    wr_t  cm;

    assign w0_eff       = bus.w0_we && (bus.w0_addr != '0);
    assign bus.w1_ready = reset && !hold_valid_q;
    assign w1_fire      = bus.w1_valid && bus.w1_ready;
    assign w1_live      = w1_fire && (bus.w1_addr != '0);

    // Pick at most one commit: W0, else the held MDU entry, else a live W1
    always_comb begin
        cm_valid = 1'b0;
        hold_cm  = 1'b0;
        cm       = '0;
        if (reset) begin
            if (w0_eff) begin
                cm_valid = 1'b1;
                cm       = '{addr: bus.w0_addr, data: bus.w0_data, pc: bus.w0_pc};
            end else if (hold_valid_q) begin
                cm_valid = 1'b1;
                hold_cm  = 1'b1;
                cm       = hold_q;
            end else if (w1_live) begin
                cm_valid = 1'b1;
                cm       = '{addr: bus.w1_addr, data: bus.w1_data, pc: bus.w1_pc};
            end
        end
    end

    // Hold buffer: drains when W0 idles, dies when W0 overwrites its address,
    // and captures a live W1 that lost to W0 (unless W0 targets the same register)
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_d       = hold_q;
        if (!reset) begin
            hold_valid_d = 1'b0;
        end else if (hold_valid_q) begin
            if (hold_cm || (w0_eff && bus.w0_addr == hold_q.addr))
                hold_valid_d = 1'b0;
        end else if (w1_live && w0_eff && bus.w1_addr != bus.w0_addr) begin
            hold_valid_d = 1'b1;
            hold_d       = '{addr: bus.w1_addr, data: bus.w1_data, pc: bus.w1_pc};
        end
    end

    // Array next state: clear everything on reset, otherwise apply the commit
    always_comb begin
        mem_d = mem_q;
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
        end else if (cm_valid) begin
            mem_d[cm.addr] = cm.data;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        mem_q        <= mem_d;
        hold_valid_q <= hold_valid_d;
        hold_q       <= hold_d;
    end

    assign bus.trace_valid = cm_valid;
    assign bus.trace_addr  = cm.addr;
    assign bus.trace_data  = cm.data;
    assign bus.trace_pc    = cm.pc;

    for (genvar i = 0; i < NUM_RD; i++) begin : gen_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] arr;
        assign addr = bus.rd_addr[i*ADDR_W +: ADDR_W];
        assign arr  = mem_q[addr];

        grf_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd (
            .rd_addr    (addr),
            .arr_data   (arr),
            .cm_valid   (cm_valid),
            .cm_addr    (cm.addr),
            .cm_data    (cm.data),
            .hold_open  (reset && hold_valid_q && !hold_cm),
            .hold_addr  (hold_q.addr),
            .rd_data    (bus.rd_data[i*DATA_W +: DATA_W]),
            .rd_pending (bus.rd_pending[i])
        );
    end
endmodule

// File: tb/tb_grf_param.sv
// Bench for grf_param (64-bit, 16 registers, 3 read ports): directed
// scenarios with literal expectations, then randomized traffic against a
// reference model of the register file and pending MDU result.
module tb_grf_param;
    localparam int DW = 64;
    localparam int AW = 4;
    localparam int NR = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    grf_param_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();
    grf_param #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: architectural registers plus at most one pending MDU result
    logic [DW-1:0] ref_regs [16];
    bit            ref_known = 0;
    bit            pend_v = 0;
    int            pend_a;
    logic [DW-1:0] pend_d;
    logic [31:0]   pend_pc;
    // Decisions for the current cycle: 0 none, 1 W0, 2 pending, 3 W1
    int            src;
    int            c_a;
    logic [DW-1:0] c_d;
    logic [31:0]   c_pc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Work out what the register file must present for the current inputs
    task automatic check_model();
        bit w0_ok, rdy, w1_ok;
        logic [DW-1:0] exp_rd;
        int a;
        w0_ok = bus.w0_we && bus.w0_addr != 0;
        rdy   = reset && !pend_v;
        w1_ok = bus.w1_valid && rdy && bus.w1_addr != 0;
        src = 0; c_a = 0; c_d = '0; c_pc = '0;
        if (reset) begin
            if (w0_ok)       begin src = 1; c_a = bus.w0_addr; c_d = bus.w0_data; c_pc = bus.w0_pc; end
            else if (pend_v) begin src = 2; c_a = pend_a;      c_d = pend_d;      c_pc = pend_pc;   end
            else if (w1_ok)  begin src = 3; c_a = bus.w1_addr; c_d = bus.w1_data; c_pc = bus.w1_pc; end
        end
        chk("w1_ready",    64'(bus.w1_ready),    64'(rdy));
        chk("trace_valid", 64'(bus.trace_valid), 64'(src != 0));
        chk("trace_addr",  64'(bus.trace_addr),  64'(c_a));
        chk("trace_data",  bus.trace_data,       c_d);
        chk("trace_pc",    64'(bus.trace_pc),    64'(c_pc));
        for (int i = 0; i < NR; i++) begin
            a = bus.rd_addr[i*AW +: AW];
            if (a == 0)                       exp_rd = '0;
            else if (src != 0 && c_a == a)    exp_rd = c_d;
            else                              exp_rd = ref_regs[a];
            if (ref_known) chk($sformatf("rd_data%0d", i), bus.rd_data[i*DW +: DW], exp_rd);
            chk($sformatf("rd_pending%0d", i), 64'(bus.rd_pending[i]),
                64'(reset && pend_v && pend_a == a && a != 0 && src != 2));
        end
    endtask

    // Advance the model across the rising edge, then move past it
    task automatic tick();
        bit w0_ok, w1_ok;
        w0_ok = bus.w0_we && bus.w0_addr != 0;
        w1_ok = bus.w1_valid && reset && !pend_v && bus.w1_addr != 0;
        if (!reset) begin
            for (int i = 0; i < 16; i++) ref_regs[i] = '0;
            ref_known = 1;
            pend_v = 0;
        end else begin
            if (src != 0) ref_regs[c_a] = c_d;
            if (src == 2) pend_v = 0;
            else if (pend_v && w0_ok && bus.w0_addr == pend_a) pend_v = 0;
            else if (!pend_v && w1_ok && w0_ok && bus.w1_addr != bus.w0_addr) begin
                pend_v = 1; pend_a = bus.w1_addr; pend_d = bus.w1_data; pend_pc = bus.w1_pc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        check_model();
    endtask

    task automatic idle();
        bus.w0_we = 0; bus.w0_addr = '0; bus.w0_data = '0; bus.w0_pc = '0;
        bus.w1_valid = 0; bus.w1_addr = '0; bus.w1_data = '0; bus.w1_pc = '0;
    endtask

    task automatic w0(input int a, input logic [DW-1:0] d, input logic [31:0] pc);
        bus.w0_we = 1; bus.w0_addr = AW'(a); bus.w0_data = d; bus.w0_pc = pc;
    endtask

    task automatic w1(input int a, input logic [DW-1:0] d, input logic [31:0] pc);
        bus.w1_valid = 1; bus.w1_addr = AW'(a); bus.w1_data = d; bus.w1_pc = pc;
    endtask

    task automatic rd(input int a0, input int a1, input int a2);
        bus.rd_addr = {AW'(a2), AW'(a1), AW'(a0)};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 0;
        idle();
        rd(0, 0, 0);
        #1;
        // Power-up reset: array contents unknown, only control outputs checked
        @(negedge clk);
        chk("por_w1_ready", 64'(bus.w1_ready), 64'd0);
        chk("por_trace_valid", 64'(bus.trace_valid), 64'd0);
        chk("por_rd_pending", 64'(bus.rd_pending), 64'd0);
        tick();
        reset = 1;

        // Reset clear
        w0(5, 64'hDEADBEEF, 32'h100); rd(5, 0, 0);
        settle(); chk("x5_bypass", bus.rd_data[0 +: DW], 64'hDEADBEEF); tick();
        idle(); reset = 0;
        settle();
        chk("rst_keeps_old", bus.rd_data[0 +: DW], 64'hDEADBEEF);
        chk("rst_w1_ready", 64'(bus.w1_ready), 64'd0);
        tick();
        reset = 1;
        settle();
        chk("x5_cleared", bus.rd_data[0 +: DW], 64'd0);
        chk("post_rst_ready", 64'(bus.w1_ready), 64'd1);
        tick();

        // Bypass and x0
        w0(3, 64'h12345678, 32'h200); rd(3, 0, 0);
        settle(); chk("x3_bypass", bus.rd_data[0 +: DW], 64'h12345678); tick();
        w0(0, 64'hFFFFFFFF, 32'h204); rd(0, 3, 0);
        settle();
        chk("x0_read", bus.rd_data[0 +: DW], 64'd0);
        chk("x0_no_trace", 64'(bus.trace_valid), 64'd0);
        chk("x3_array", bus.rd_data[DW +: DW], 64'h12345678);
        tick();

        // W1 direct commit
        idle(); w1(7, 64'hA5A5A5A5, 32'h3000);
        settle();
        chk("w1_tr_addr", 64'(bus.trace_addr), 64'd7);
        chk("w1_tr_data", bus.trace_data, 64'hA5A5A5A5);
        chk("w1_tr_pc", 64'(bus.trace_pc), 64'h3000);
        tick();
        idle(); rd(7, 0, 0);
        settle(); chk("x7_array", bus.rd_data[0 +: DW], 64'hA5A5A5A5); tick();

        // W1 hold, kept held one more cycle by continued W0 traffic
        w0(2, 64'h22, 32'h400); w1(9, 64'h11, 32'h500); rd(0, 9, 0);
        settle(); chk("hold_cap_tr", 64'(bus.trace_addr), 64'd2); tick();
        idle(); w0(2, 64'h23, 32'h404);
        settle();
        chk("hold_ready", 64'(bus.w1_ready), 64'd0);
        chk("hold_pending", 64'(bus.rd_pending[1]), 64'd1);
        tick();
        idle();
        settle();
        chk("hold_cm_addr", 64'(bus.trace_addr), 64'd9);
        chk("hold_cm_data", bus.trace_data, 64'h11);
        chk("hold_pend_clr", 64'(bus.rd_pending[1]), 64'd0);
        tick();

        // Ordering drop
        w0(2, 64'h24, 32'h408); w1(4, 64'h1, 32'h600);
        settle(); tick();
        idle(); w0(4, 64'h2, 32'h40C); rd(4, 0, 0);
        settle(); chk("drop_w0_data", bus.trace_data, 64'h2); tick();
        idle();
        settle();
        chk("drop_no_trace", 64'(bus.trace_valid), 64'd0);
        chk("drop_x4", bus.rd_data[0 +: DW], 64'h2);
        tick();

        // Same-address simultaneous write, then W0 to x0 with a held entry
        w0(6, 64'h66, 32'h410); w1(6, 64'h77, 32'h700);
        settle(); tick();
        idle();
        settle(); chk("same_addr_ready", 64'(bus.w1_ready), 64'd1); tick();
        w0(2, 64'h25, 32'h414); w1(8, 64'h88, 32'h704); settle(); tick();
        idle(); w0(0, 64'h99, 32'h418);
        settle(); chk("x0_w0_hold_cm", bus.trace_data, 64'h88); tick();

        // Randomized traffic
        for (int c = 0; c < 10000; c++) begin
            reset = ($urandom_range(0, 99) != 0);
            bus.w0_we    = $urandom_range(0, 1);
            bus.w0_addr  = AW'($urandom_range(0, 7));
            bus.w0_data  = {$urandom, $urandom};
            bus.w0_pc    = $urandom;
            bus.w1_valid = ($urandom_range(0, 9) < 6);
            bus.w1_addr  = AW'($urandom_range(0, 7));
            bus.w1_data  = {$urandom, $urandom};
            bus.w1_pc    = $urandom;
            rd($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7));
            settle();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
